// File: rtl/phy_write_sequencer.sv
// Per-channel WRITE sequencer: pulls one burst from the Write Buffer into the PHY
// write FIFO, waits out tCWL from command accept, then grants DQ drive until ACK.
module phy_write_sequencer #(
    parameter int MEM_DATAWIDTH = 64,
    parameter int BURST_LENGTH  = 8,
    parameter int T_CWL         = 12,
    parameter int TAG_WIDTH     = 4,
    parameter int ACK_TIMEOUT   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    input  logic [TAG_WIDTH-1:0]                  cmd_tag,
    output logic                                  cmd_ready,
    input  logic                                  wb_valid,
    input  logic [MEM_DATAWIDTH-1:0]              wb_data,
    input  logic [MEM_DATAWIDTH/BURST_LENGTH-1:0] wb_strb,
    output logic                                  wb_ready,
    output logic                                  phy_inflag,
    output logic [MEM_DATAWIDTH-1:0]              phy_indata,
    output logic [MEM_DATAWIDTH/BURST_LENGTH-1:0] phy_instrb,
    output logic                                  phy_outflag,
    input  logic                                  phy_ack,
    output logic                                  wr_done,
    output logic [TAG_WIDTH-1:0]                  wr_done_tag,
    output logic [1:0]                            wr_err
);

    localparam int STRB_W = MEM_DATAWIDTH / BURST_LENGTH;
    localparam int BEAT_W = $clog2(BURST_LENGTH) + 1;
    localparam int ACK_W  = $clog2(ACK_TIMEOUT);
    localparam int CWL_W  = 8;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_CWL, DRIVE, DONE} state_t;
    typedef enum logic [1:0] {ERR_OK, ERR_UNDERRUN, ERR_LATE, ERR_TIMEOUT} err_t;

    typedef struct packed {
        logic [MEM_DATAWIDTH-1:0] data;
        logic [STRB_W-1:0]        strb;
    } beat_t;

    state_t               state, state_nxt;
    err_t                 err_q, err_nxt;
    logic [CWL_W-1:0]     cwl_cnt;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [ACK_W-1:0]     ack_cnt;
    logic [TAG_WIDTH-1:0] tag_q;
    beat_t                beat_q;
    logic                 inflag_q, outflag_q;
    logic                 accept, take, cwl_zero, last_beat;

    assign cwl_zero  = (cwl_cnt == '0);
    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_ready && cmd_valid;
    // Stop pulling beats on the cycle the burst is declared late so none is lost.
    assign wb_ready  = (state == FETCH) && !cwl_zero;
    assign take      = wb_ready && wb_valid;
    assign last_beat = take && (beat_cnt == BEAT_W'(BURST_LENGTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            err_q <= ERR_OK;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = FETCH;
                    err_nxt   = ERR_OK;
                end
            end
            FETCH: begin
                if (cwl_zero) begin
                    state_nxt = DONE;
                    err_nxt   = ERR_LATE;
                end else if (last_beat) begin
                    state_nxt = WAIT_CWL;
                end else if (!wb_valid && beat_cnt != '0) begin
                    state_nxt = DONE;
                    err_nxt   = ERR_UNDERRUN;
                end
            end
            WAIT_CWL: begin
                if (cwl_zero) state_nxt = DRIVE;
            end
            DRIVE: begin
                if (phy_ack) begin
                    state_nxt = DONE;
                    err_nxt   = ERR_OK;
                end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                    state_nxt = DONE;
                    err_nxt   = ERR_TIMEOUT;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cwl_cnt   <= '0;
            beat_cnt  <= '0;
            ack_cnt   <= '0;
            tag_q     <= '0;
            beat_q    <= '0;
            inflag_q  <= 1'b0;
            outflag_q <= 1'b0;
        end else begin
            if (accept) begin
                tag_q   <= cmd_tag;
                cwl_cnt <= CWL_W'(T_CWL - 1);
            end else if ((state == FETCH || state == WAIT_CWL) && !cwl_zero) begin
                cwl_cnt <= cwl_cnt - CWL_W'(1);
            end
            if (accept)    beat_cnt <= '0;
            else if (take) beat_cnt <= beat_cnt + BEAT_W'(1);
            ack_cnt   <= (state == DRIVE) ? ack_cnt + ACK_W'(1) : '0;
            if (take) beat_q <= '{data: wb_data, strb: wb_strb};
            inflag_q  <= take;
            outflag_q <= (state_nxt == DRIVE);
        end
    end

    assign phy_inflag  = inflag_q;
    assign phy_indata  = beat_q.data;
    assign phy_instrb  = beat_q.strb;
    assign phy_outflag = outflag_q;
    assign wr_done     = (state == DONE);
    assign wr_done_tag = wr_done ? tag_q : '0;
    assign wr_err      = wr_done ? err_q : ERR_OK;

endmodule

// File: tb/tb_phy_write_sequencer.sv
// Bench for phy_write_sequencer: directed scenarios plus randomized bursts checked
// against a per-transaction timeline model derived from the burst rules.
module tb_phy_write_sequencer;

    localparam int DW   = 64;
    localparam int BL   = 8;
    localparam int SW   = DW / BL;
    localparam int TCWL = 12;
    localparam int TW   = 4;
    localparam int TO   = 16;
    localparam int N    = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic [TW-1:0] cmd_tag;
    logic          cmd_ready;
    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic [SW-1:0] wb_strb;
    logic          wb_ready;
    logic          phy_inflag;
    logic [DW-1:0] phy_indata;
    logic [SW-1:0] phy_instrb;
    logic          phy_outflag;
    logic          phy_ack;
    logic          wr_done;
    logic [TW-1:0] wr_done_tag;
    logic [1:0]    wr_err;

    phy_write_sequencer #(
        .MEM_DATAWIDTH(DW), .BURST_LENGTH(BL), .T_CWL(TCWL),
        .TAG_WIDTH(TW), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_tag(cmd_tag), .cmd_ready(cmd_ready),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_strb(wb_strb), .wb_ready(wb_ready),
        .phy_inflag(phy_inflag), .phy_indata(phy_indata), .phy_instrb(phy_instrb),
        .phy_outflag(phy_outflag), .phy_ack(phy_ack),
        .wr_done(wr_done), .wr_done_tag(wr_done_tag), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-transaction stimulus, indexed by the clock edge relative to the accept edge.
    bit            vpat[N];
    logic [DW-1:0] vdat[N];
    logic [SW-1:0] vstb[N];
    bit            apat[N];
    bit            exp_in[N];
    bit            exp_out[N];
    int            fl;
    logic [DW-1:0] last_dat = '0;
    logic [SW-1:0] last_stb = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_cmd_ready"}, cmd_ready, 1);
        chk({pfx, "_wb_ready"}, wb_ready, 0);
        chk({pfx, "_inflag"}, phy_inflag, 0);
        chk({pfx, "_indata"}, phy_indata, 0);
        chk({pfx, "_instrb"}, phy_instrb, 0);
        chk({pfx, "_outflag"}, phy_outflag, 0);
        chk({pfx, "_wr_done"}, wr_done, 0);
        chk({pfx, "_tag"}, wr_done_tag, 0);
        chk({pfx, "_err"}, wr_err, 0);
    endtask

    // Burst timeline: beats land one edge later on inflag; late at edge T_CWL;
    // outflag from edge T_CWL until ACK (seen from edge T_CWL+1) or TO cycles.
    task automatic model(output int d, output logic [1:0] e);
        int beats, fe, k;
        beats = 0; fe = -1; d = -1; e = 0;
        for (int i = 0; i < N; i++) begin exp_in[i] = 0; exp_out[i] = 0; end
        k = 1;
        while (d < 0 && fe < 0) begin
            if (k == TCWL) begin d = k; e = 2; end
            else if (vpat[k]) begin
                exp_in[k] = 1; beats++;
                if (beats == BL) fe = k;
            end else if (beats > 0) begin d = k; e = 1; end
            k++;
        end
        fl = (fe >= 0) ? fe : d;
        if (fe >= 0) begin
            for (int j = TCWL; j < N && d < 0; j++) begin
                if (j > TCWL && apat[j]) begin d = j; e = 0; end
                else if (j - TCWL == TO) begin d = j; e = 3; end
                else exp_out[j] = 1;
            end
        end
    endtask

    task automatic run_txn(input logic [TW-1:0] tag, input int kind, input bit hold);
        int d, s, nb, fire;
        logic [1:0] e;
        for (int i = 0; i < N; i++) begin
            vpat[i] = 0;
            vdat[i] = {$urandom, $urandom};
            vstb[i] = SW'($urandom);
            apat[i] = (kind == 5) ? ($urandom_range(0, 9) == 0) : 1'b0;
        end
        case (kind)
            0, 4: for (int i = 1; i <= BL; i++) begin
                vpat[i] = 1; vdat[i] = 64'(i) * 64'h11; vstb[i] = '1;
            end
            1: for (int i = 1; i <= BL; i++) vpat[i + 2] = 1;
            2: for (int i = 1; i <= 3; i++) vpat[i] = 1;
            3: ;
            default: begin
                s  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 13) : $urandom_range(1, 3);
                nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, BL - 1) : BL;
                for (int i = 0; i < nb; i++) vpat[s + i] = 1;
                fire = $urandom_range(1, 20);
                for (int j = TCWL + 1; j <= TCWL + TO; j++) apat[j] = 0;
                if (fire <= TO) apat[TCWL + fire] = 1;
            end
        endcase
        if (kind == 0 || kind == 1) apat[TCWL + 4] = 1;
        model(d, e);
        cmd_valid = 1; cmd_tag = tag; wb_valid = 0; phy_ack = 0;
        @(posedge clk);
        for (int k = 0; k <= d + 1; k++) begin
            @(negedge clk);
            if (exp_in[k]) begin last_dat = vdat[k]; last_stb = vstb[k]; end
            chk("cmd_ready", cmd_ready, k > d);
            chk("wb_ready", wb_ready, (k < fl) && (k + 1 < TCWL));
            chk("inflag", phy_inflag, exp_in[k]);
            chk("indata", phy_indata, last_dat);
            chk("instrb", phy_instrb, last_stb);
            chk("outflag", phy_outflag, exp_out[k]);
            chk("flag_excl", phy_inflag & phy_outflag, 0);
            chk("wr_done", wr_done, k == d);
            if (k == d) begin
                chk("done_tag", wr_done_tag, tag);
                chk("done_err", wr_err, e);
            end
            cmd_valid = hold;
            wb_valid  = vpat[k + 1];
            wb_data   = vdat[k + 1];
            wb_strb   = vstb[k + 1];
            phy_ack   = apat[k + 1];
        end
        cmd_valid = 0; wb_valid = 0; phy_ack = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1; cmd_valid = 0; cmd_tag = '0; wb_valid = 0; wb_data = '0; wb_strb = '0; phy_ack = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("rst");
        rst = 0;

        run_txn(4'd5, 0, 0);   // nominal
        run_txn(4'd6, 1, 0);   // stalled start
        run_txn(4'd7, 2, 0);   // underrun after beat 3
        run_txn(4'd8, 3, 0);   // late data
        run_txn(4'd9, 4, 0);   // ACK timeout
        run_txn(4'd10, 0, 1);  // command held while busy
        run_txn(4'd10, 1, 0);  // held command taken once idle

        // Reset in the middle of FETCH: no completion may follow.
        cmd_valid = 1; cmd_tag = 4'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0; wb_valid = 1; wb_strb = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            wb_data = {$urandom, $urandom};
            @(negedge clk);
        end
        rst = 1; wb_valid = 0;
        @(negedge clk);
        chk_idle("midrst");
        rst = 0; last_dat = '0; last_stb = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst_done", wr_done, 0);
            chk("post_rst_outflag", phy_outflag, 0);
            chk("post_rst_ready", cmd_ready, 1);
        end

        for (int t = 0; t < 40; t++) begin
            run_txn(TW'($urandom), 5, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("gap_ready", cmd_ready, 1);
                chk("gap_done", wr_done, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
